// File: rtl/sclk_monitor_if.sv
// Signal bundle between the sclk monitor and the logic that drives and observes it.
// The master side drives sclk_in/enable; the slave side is the monitor itself.
interface sclk_monitor_if;
    logic        sclk_in;
    logic        enable;
    logic [31:0] half_period;
    logic        meas_valid;
    logic        in_range;
    logic        timeout;
    logic [15:0] edge_count;

    modport master (
        output sclk_in, enable,
        input  half_period, meas_valid, in_range, timeout, edge_count
    );

    modport slave (
        input  sclk_in, enable,
        output half_period, meas_valid, in_range, timeout, edge_count
    );
endinterface

// File: rtl/sclk_monitor.sv
// Measures the clk-cycle spacing between edges of a slow, asynchronous sclk,
// flags measurements outside the nominal window and detects a stalled sclk.
module sclk_monitor #(
    parameter int unsigned EXPECTED_HALF = 9000001,
    parameter int unsigned TOL           = 16,
    parameter int unsigned TIMEOUT       = 18000002
) (
    input  logic          clk,
    input  logic          reset,
    sclk_monitor_if.slave mon
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    // Window bounds are kept one bit wider so EXPECTED_HALF + TOL cannot wrap.
    localparam logic [32:0] LOW_BOUND  = (TOL > EXPECTED_HALF) ? 33'd0
                                       : (33'(EXPECTED_HALF) - 33'(TOL));
    localparam logic [32:0] HIGH_BOUND = 33'(EXPECTED_HALF) + 33'(TOL);
    localparam logic [31:0] CNT_LIMIT  = 32'(TIMEOUT - 1);

    logic        s1;
    logic        s2;
    logic        s3;
    logic [1:0]  state;
    logic [31:0] cnt;
    logic [31:0] half_period_r;
    logic        meas_valid_r;
    logic        in_range_r;
    logic        timeout_r;
    logic [15:0] edge_count_r;

    logic        sclk_edge;
    logic [31:0] cnt_plus1;
    logic        in_window;
    logic        at_limit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon.sclk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sclk_edge = s2 ^ s3;
    assign cnt_plus1 = cnt + 32'd1;
    assign in_window = ({1'b0, cnt_plus1} >= LOW_BOUND) && ({1'b0, cnt_plus1} <= HIGH_BOUND);
    assign at_limit  = (cnt == CNT_LIMIT);

    // An edge on the limit cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= 32'd0;
            half_period_r <= 32'd0;
            meas_valid_r  <= 1'b0;
            in_range_r    <= 1'b0;
            timeout_r     <= 1'b0;
            edge_count_r  <= 16'd0;
        end else begin
            meas_valid_r <= 1'b0;
            if (!mon.enable) begin
                state     <= IDLE;
                cnt       <= 32'd0;
                timeout_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt       <= 32'd0;
                        timeout_r <= 1'b0;
                        state     <= ARM;
                    end
                    ARM: begin
                        cnt <= 32'd0;
                        if (sclk_edge) begin
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (sclk_edge) begin
                            half_period_r <= cnt_plus1;
                            in_range_r    <= in_window;
                            meas_valid_r  <= 1'b1;
                            edge_count_r  <= edge_count_r + 16'd1;
                            cnt           <= 32'd0;
                        end else if (at_limit) begin
                            timeout_r <= 1'b1;
                            cnt       <= 32'd0;
                            state     <= ARM;
                        end else begin
                            cnt <= cnt_plus1;
                        end
                    end
                    default: begin
                        cnt   <= 32'd0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mon.half_period = half_period_r;
    assign mon.meas_valid  = meas_valid_r;
    assign mon.in_range    = in_range_r;
    assign mon.timeout     = timeout_r;
    assign mon.edge_count  = edge_count_r;

endmodule
